time_entry_register: RTL and testbench

TIME_ENTRY_REGISTER -- requirements
Module: time_entry_register

---
 rtl/microwave_pkg.sv | 13 +
 rtl/time_entry_register_if.sv | 17 +
 rtl/key_debouncer.sv | 29 ++
 rtl/time_entry_register.sv | 107 ++++++++++
 tb/tb_time_entry_register.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared constants and FSM state type for the time-entry keypad path.
// TIME_ENTRY_DEBOUNCE_EN selects whether the DEBOUNCE state exists.
package microwave_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

`ifdef TIME_ENTRY_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd2} state_t;
`endif
endpackage

// File: rtl/time_entry_register_if.sv
// Key-entry bundle: encoder/control inputs and the BCD entry outputs.
interface time_entry_register_if;
  import microwave_pkg::*;
  logic [BCD_W-1:0]            D;
  logic                        valid;
  logic                        enablen;
  logic                        clear;
  logic [NUM_DIGITS*BCD_W-1:0] digits;
  logic [2:0]                  digit_count;
  logic                        key_strobe;
  logic                        nonzero;

  modport master (output D, valid, enablen, clear,
                  input  digits, digit_count, key_strobe, nonzero);
  modport slave  (input  D, valid, enablen, clear,
                  output digits, digit_count, key_strobe, nonzero);
endinterface

// File: rtl/key_debouncer.sv
// Stability counter and code compare for a captured key; only built with
// TIME_ENTRY_DEBOUNCE_EN.
module key_debouncer
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             active,
  input  logic [BCD_W-1:0] d,
  input  logic [BCD_W-1:0] key_code,
  input  logic             valid,
  input  logic             enablen,
  output logic             stable,
  output logic             done
);
  logic [7:0] cnt;

  assign stable = valid && enablen && (d == key_code);
  assign done   = stable && (cnt == 8'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (start)                     cnt <= '0;
    else if (active && stable && !done) cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/time_entry_register.sv
// Microwave time-entry shift register: accepts debounced BCD keys into a
// 4-digit entry. TIME_ENTRY_DEBOUNCE_EN enables the debounce stage.
module time_entry_register
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  time_entry_register_if.slave bus
);
  state_t                      state, nxt;
  logic                        accept, capture;
  logic [BCD_W-1:0]            code;
  logic [NUM_DIGITS*BCD_W-1:0] digits_q;
  logic [2:0]                  cnt_q;
  logic                        strobe_q;

`ifdef TIME_ENTRY_DEBOUNCE_EN
  logic [BCD_W-1:0] key_code;
  logic             stable, done;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (capture),
    .active  (state == DEBOUNCE),
    .d       (bus.D),
    .key_code(key_code),
    .valid   (bus.valid),
    .enablen (bus.enablen),
    .stable  (stable),
    .done    (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       key_code <= '0;
    else if (capture) key_code <= bus.D;
  end
  assign code = key_code;
`else
  // Without debounce the live code is accepted on the capture edge.
  wire [7:0] unused_dc = 8'(DEBOUNCE_CYCLES);
  assign code = bus.D;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: if (bus.valid && bus.enablen) begin
        capture = 1'b1;
`ifdef TIME_ENTRY_DEBOUNCE_EN
        nxt     = DEBOUNCE;
`else
        accept  = 1'b1;
        nxt     = HELD;
`endif
      end
`ifdef TIME_ENTRY_DEBOUNCE_EN
      DEBOUNCE: begin
        if (!stable) nxt = IDLE;
        else if (done) begin
          accept = 1'b1;
          nxt    = HELD;
        end
      end
`endif
      HELD:    if (!bus.valid) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // Clear wins over any accept; a still-pressed key must be released first.
    if (bus.clear) begin
      accept = 1'b0;
      nxt    = bus.valid ? HELD : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (bus.clear) begin
        digits_q <= '0;
        cnt_q    <= '0;
      end else if (accept && code <= BCD_MAX && cnt_q < 3'(NUM_DIGITS)) begin
        digits_q <= {digits_q[(NUM_DIGITS-1)*BCD_W-1:0], code};
        cnt_q    <= cnt_q + 3'd1;
        strobe_q <= 1'b1;
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_count = cnt_q;
  assign bus.key_strobe  = strobe_q;
  assign bus.nonzero     = |digits_q;
endmodule

// File: tb/tb_time_entry_register.sv
// Self-checking bench for time_entry_register: directed scenarios plus random
// key activity against a run-length key model. Honors TIME_ENTRY_DEBOUNCE_EN.
module tb_time_entry_register;
  localparam int DC = 4;
`ifdef TIME_ENTRY_DEBOUNCE_EN
  localparam int THR = DC + 1;
`else
  localparam int THR = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  time_entry_register_if tif();

  time_entry_register #(.DEBOUNCE_CYCLES(DC)) dut (.clk(clk), .rst_n(rst_n), .bus(tif));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, nstb = 0;
  int mq[$];
  int m_run = 0, m_code = 0;
  bit m_blk = 1'b0, m_strobe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_digits();
    logic [15:0] e = '0;
    foreach (mq[i]) e = {e[11:0], 4'(mq[i])};
    return e;
  endfunction

  // A key counts once it has been seen valid, enabled and unchanged for THR
  // consecutive edges; afterwards it is blocked until valid drops.
  task automatic model_step();
    bit ok = tif.valid && tif.enablen;
    m_strobe = 1'b0;
    if (tif.clear) begin
      mq.delete();
      m_blk = tif.valid;
      m_run = 0;
    end else if (m_blk) begin
      if (!tif.valid) m_blk = 1'b0;
    end else if (m_run > 0 && (!ok || int'(tif.D) != m_code)) begin
      m_run = 0;
    end else if (ok) begin
      if (m_run == 0) m_code = int'(tif.D);
      m_run++;
      if (m_run == THR) begin
        m_blk = 1'b1;
        m_run = 0;
        if (m_code <= 9 && mq.size() < 4) begin
          mq.push_back(m_code);
          m_strobe = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_blk = 1'b0; m_strobe = 1'b0;
  endtask

  task automatic check_outputs();
    chk("digits", 32'(tif.digits), 32'(exp_digits()));
    chk("digit_count", 32'(tif.digit_count), 32'(mq.size()));
    chk("key_strobe", 32'(tif.key_strobe), 32'(m_strobe));
    chk("nonzero", 32'(tif.nonzero), 32'(exp_digits() != 16'h0));
  endtask

  // Called just after a falling edge: drive, clock once, check on next fall.
  task automatic cyc(input bit v, input logic [3:0] d, input bit en, input bit clr);
    tif.valid = v; tif.D = d; tif.enablen = en; tif.clear = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (tif.key_strobe) nstb++;
    check_outputs();
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int gap, input bit en);
    for (int i = 0; i < hold; i++) cyc(1'b1, d, en, 1'b0);
    for (int i = 0; i < gap; i++)  cyc(1'b0, d, en, 1'b0);
  endtask

  initial begin
    tif.valid = 1'b0; tif.D = '0; tif.enablen = 1'b1; tif.clear = 1'b0;
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 4; k++) press(4'(k), 10, 3, 1'b1);
    chk("seq1234", 32'(tif.digits), 32'h1234);
    chk("seq_count", 32'(tif.digit_count), 32'd4);
    chk("seq_strobes", 32'(nstb), 32'd4);
    chk("seq_nonzero", 32'(tif.nonzero), 32'd1);

    nstb = 0;
    press(4'd9, 10, 3, 1'b1);
    chk("full_hold", 32'(tif.digits), 32'h1234);
    chk("full_nostb", 32'(nstb), 32'd0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("clear", 32'(tif.digits), 32'h0);
    chk("clear_nz", 32'(tif.nonzero), 32'd0);

    press(4'd7, 10, 3, 1'b0);
    chk("enablen_low", 32'(tif.digits), 32'h0);

    press(4'd8, 2, 0, 1'b1);
    cyc(1'b1, 4'd8, 1'b1, 1'b1);
    press(4'd8, 8, 3, 1'b1);
    chk("clr_held8", 32'(tif.digits), 32'h0);
    press(4'd8, 10, 3, 1'b1);
    chk("repress8", 32'(tif.digits), 32'h0008);

    press(4'd3, 10, 3, 1'b1);
    chk("pre_rst", 32'(tif.digits), 32'h0083);
    press(4'd6, 2, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #3 rst_n = 1'b1;
    press(4'd6, 8, 3, 1'b1);
    chk("rst_reaccept", 32'(tif.digits), 32'h0006);

    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    press(4'd5, 2, 1, 1'b1);
    press(4'd5, 10, 3, 1'b1);
`ifdef TIME_ENTRY_DEBOUNCE_EN
    chk("bounce", 32'(tif.digits), 32'h0005);
`else
    chk("bounce", 32'(tif.digits), 32'h0055);
`endif

    begin
      bit v = 1'b0, en = 1'b1, clr;
      logic [3:0] d = '0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 3) == 0) v = ~v;
        if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) en = ~en;
        clr = ($urandom_range(0, 39) == 0);
        cyc(v, d, en, clr);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
